hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core; produces the stall/bubble/flush controls consumed by the ID-stage control-bubble mux, PC, IF/ID and the later pipeline registers.
- Detects load-use hazards, taken-branch flushes and data-memory wait stalls.
- Sequences multi-cycle bubbles and memory freezes with a small FSM and keeps a saturating stall-cycle counter.
- `ctrl_keep_o` drives the bubble mux select: 1 = pass ID control fields, 0 = zero WB/EX/MEM control.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, field widths and the
// bundle of hazard controls presented to the pipeline.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned WB_W  = 2;
    localparam int unsigned EX_W  = 4;
    localparam int unsigned MEM_W = 2;
    localparam int unsigned BUB_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic ctrl_keep;
        logic pipe_en;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                        ctrl_keep: 1'b1, pipe_en: 1'b1};
    localparam hz_ctrl_t CTL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                        ctrl_keep: 1'b0, pipe_en: 1'b1};
    localparam hz_ctrl_t CTL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                        ctrl_keep: 1'b1, pipe_en: 1'b0};
    localparam hz_ctrl_t CTL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                        ctrl_keep: 1'b1, pipe_en: 1'b1};
    localparam hz_ctrl_t CTL_RST    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                        ctrl_keep: 1'b0, pipe_en: 1'b1};

    // Load in EX writes a register the instruction in ID reads ($zero never counts).
    function automatic logic load_use_f(
        input logic             memread,
        input logic [REG_W-1:0] idex_rt,
        input logic [REG_W-1:0] ifid_rs,
        input logic [REG_W-1:0] ifid_rt
    );
        return memread && (idex_rt != '0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush and
// data-memory freeze, plus a saturating count of PC-stall cycles.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             ctrl_keep_o,
    output logic             pipe_en_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    hz_state_e        state_q, state_d;
    logic [BUB_W-1:0] bub_q, bub_d;
    logic             resume_q, resume_d;
    hz_ctrl_t         ctl;
    logic             load_use;
    logic             mem_stall;

    assign load_use  = load_use_f(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i);
    assign mem_stall = mem_req_i && !mem_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= RUN;
            bub_q    <= '0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bub_q    <= bub_d;
            resume_q <= resume_d;
        end
    end

    // Next state and controls; memory freeze outranks bubbles, bubbles outrank flush.
    always_comb begin
        ctl      = CTL_RUN;
        state_d  = state_q;
        bub_d    = bub_q;
        resume_d = resume_q;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    ctl      = CTL_FREEZE;
                    state_d  = MEM_WAIT;
                    resume_d = 1'b0;
                end else if (load_use) begin
                    ctl = CTL_BUBBLE;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = BUBBLE;
                        bub_d   = BUB_W'(LOAD_BUBBLES - 1);
                    end
                end else if (branch_taken_i) begin
                    ctl = CTL_FLUSH;
                end
            end
            BUBBLE: begin
                if (mem_stall) begin
                    ctl      = CTL_FREEZE;
                    state_d  = MEM_WAIT;
                    resume_d = 1'b1;
                end else begin
                    ctl   = CTL_BUBBLE;
                    bub_d = bub_q - BUB_W'(1);
                    if (bub_q <= BUB_W'(1)) begin
                        state_d = RUN;
                        bub_d   = '0;
                    end
                end
            end
            MEM_WAIT: begin
                ctl = CTL_FREEZE;
                if (!mem_stall) begin
                    ctl.pipe_en = 1'b1;
                    state_d     = resume_q ? BUBBLE : RUN;
                    resume_d    = 1'b0;
                end
            end
            default: begin
                state_d  = RUN;
                bub_d    = '0;
                resume_d = 1'b0;
            end
        endcase
        if (!rst_i) begin
            ctl = CTL_RST;
        end
    end

    assign pc_write_o   = ctl.pc_write;
    assign ifid_write_o = ctl.ifid_write;
    assign ifid_flush_o = ctl.ifid_flush;
    assign ctrl_keep_o  = ctl.ctrl_keep;
    assign pipe_en_o    = ctl.pipe_en;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (!ctl.pc_write),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations share stimulus; directed
// table, corner sequences and random traffic checked against a cycle model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       memread;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       req;
        logic       ready;
    } in_t;

    // bit order matches {pc_write, ifid_write, ifid_flush, ctrl_keep, pipe_en}
    typedef logic [4:0] out_t;

    typedef struct {
        int owed;      // bubble cycles still owed to the pending load
        bit waiting;   // memory access outstanding
        int cnt;       // stall cycles counted so far
    } mdl_t;

    typedef struct {
        in_t  in;
        out_t exp;
        int   cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    in_t  cur = '0;

    logic [4:0]  ctl_a, ctl_b, ctl_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;

    int n_tests = 0;
    int n_fail  = 0;
    mdl_t m[3];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst_i), .idex_memread_i(cur.memread), .idex_rt_i(cur.idex_rt),
        .ifid_rs_i(cur.rs), .ifid_rt_i(cur.rt), .branch_taken_i(cur.br), .mem_req_i(cur.req),
        .mem_ready_i(cur.ready), .pc_write_o(ctl_a[4]), .ifid_write_o(ctl_a[3]),
        .ifid_flush_o(ctl_a[2]), .ctrl_keep_o(ctl_a[1]), .pipe_en_o(ctl_a[0]), .stall_cnt_o(cnt_a));

    hazard_ctrl #(.LOAD_BUBBLES(3), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst_i), .idex_memread_i(cur.memread), .idex_rt_i(cur.idex_rt),
        .ifid_rs_i(cur.rs), .ifid_rt_i(cur.rt), .branch_taken_i(cur.br), .mem_req_i(cur.req),
        .mem_ready_i(cur.ready), .pc_write_o(ctl_b[4]), .ifid_write_o(ctl_b[3]),
        .ifid_flush_o(ctl_b[2]), .ctrl_keep_o(ctl_b[1]), .pipe_en_o(ctl_b[0]), .stall_cnt_o(cnt_b));

    hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(4)) u_c (
        .clk_i(clk), .rst_i(rst_i), .idex_memread_i(cur.memread), .idex_rt_i(cur.idex_rt),
        .ifid_rs_i(cur.rs), .ifid_rt_i(cur.rt), .branch_taken_i(cur.br), .mem_req_i(cur.req),
        .mem_ready_i(cur.ready), .pc_write_o(ctl_c[4]), .ifid_write_o(ctl_c[3]),
        .ifid_flush_o(ctl_c[2]), .ctrl_keep_o(ctl_c[1]), .pipe_en_o(ctl_c[0]), .stall_cnt_o(cnt_c));

    function automatic out_t dut_ctl(input int k);
        case (k)
            0:       return ctl_a;
            1:       return ctl_b;
            default: return ctl_c;
        endcase
    endfunction

    function automatic int dut_cnt(input int k);
        case (k)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: a memory wait freezes everything, otherwise owed or new
    // load bubbles stall, otherwise a taken branch flushes.
    function automatic void model_eval(input mdl_t cm, input in_t v, input int lb, input int cmax,
                                       output out_t e, output mdl_t nm);
        bit ms = v.req && !v.ready;
        bit lu = v.memread && (v.idex_rt != 0) && (v.idex_rt == v.rs || v.idex_rt == v.rt);
        nm = cm;
        e  = 5'b11011;
        if (cm.waiting || ms) begin
            e          = {4'b0001, !ms};
            nm.waiting = ms;
        end else if (cm.owed > 0 || lu) begin
            e       = 5'b00001;
            nm.owed = ((cm.owed > 0) ? cm.owed : lb) - 1;
        end else if (v.br) begin
            e = 5'b11111;
        end
        if (e[4] == 1'b0 && nm.cnt < cmax) nm.cnt = cm.cnt + 1;
    endfunction

    task automatic step(input in_t v);
        out_t e;
        mdl_t nm;
        @(posedge clk);
        #1 cur = v;
        #1;
        for (int k = 0; k < 3; k++) begin
            model_eval(m[k], v, (k == 1) ? 3 : 1, (k == 2) ? 15 : 65535, e, nm);
            chk($sformatf("dut%0d ctl", k), int'(dut_ctl(k)), int'(e));
            chk($sformatf("dut%0d stall_cnt", k), dut_cnt(k), m[k].cnt);
            m[k] = nm;
        end
    endtask

    task automatic do_reset();
        #1 rst_i = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d reset ctl", k), int'(dut_ctl(k)), 5'b00001);
            chk($sformatf("dut%0d reset cnt", k), dut_cnt(k), 0);
        end
        cur = '0;
        @(posedge clk);
        #1 chk("dut0 reset cnt held", int'(cnt_a), 0);
        @(posedge clk);
        @(negedge clk) rst_i = 1'b1;
        for (int k = 0; k < 3; k++) m[k] = '{owed: 0, waiting: 0, cnt: 0};
    endtask

    function automatic in_t mk(input logic memread, input logic [4:0] irt, input logic [4:0] rs,
                               input logic [4:0] rt, input logic br, input logic req,
                               input logic ready);
        in_t v;
        v = '{memread: memread, idex_rt: irt, rs: rs, rt: rt, br: br, req: req, ready: ready};
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        in_t  idle;
        in_t  v;
        int   keep0;
        int   frz;

        idle = '0;
        // directed vectors for the LOAD_BUBBLES=1 instance, checked in order
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), 5'b11011, 0});  // idle
        tbl.push_back('{mk(1, 8, 8, 0, 0, 0, 0), 5'b00001, 0});  // load-use on rs
        tbl.push_back('{mk(0, 8, 8, 0, 0, 0, 0), 5'b11011, 1});  // single bubble only
        tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0), 5'b11011, 1});  // $zero never stalls
        tbl.push_back('{mk(1, 5, 0, 5, 1, 0, 0), 5'b00001, 1});  // branch held by load-use
        tbl.push_back('{mk(0, 5, 0, 5, 1, 0, 0), 5'b11111, 2});  // branch flushes alone
        tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 0), 5'b00010, 2});  // mem wait 1
        tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 0), 5'b00010, 3});  // mem wait 2
        tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 0), 5'b00010, 4});  // mem wait 3
        tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 1), 5'b00011, 5});  // access retires
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0), 5'b11011, 6});  // back in RUN, +4
        tbl.push_back('{mk(1, 9, 9, 0, 0, 1, 0), 5'b00010, 6});  // mem stall beats load-use
        tbl.push_back('{mk(1, 9, 9, 0, 1, 1, 1), 5'b00011, 7});  // load/branch ignored in wait
        tbl.push_back('{mk(1, 9, 0, 9, 0, 0, 0), 5'b00001, 8});  // load-use on rt
        tbl.push_back('{mk(0, 0, 0, 0, 1, 0, 0), 5'b11111, 9});  // plain flush

        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].in);
            chk($sformatf("vec%0d ctl", i), int'(ctl_a), int'(tbl[i].exp));
            chk($sformatf("vec%0d cnt", i), int'(cnt_a), tbl[i].cnt);
        end

        // three bubbles interrupted by a two-cycle memory wait (LOAD_BUBBLES=3)
        step(idle);
        keep0 = 0;
        frz   = 0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0:       v = mk(1, 8, 8, 0, 0, 0, 0);
                1, 2:    v = mk(0, 0, 0, 0, 0, 1, 0);
                3:       v = mk(0, 0, 0, 0, 0, 1, 1);
                default: v = idle;
            endcase
            step(v);
            if (ctl_b[1] == 1'b0) keep0++;
            if (ctl_b[4] == 1'b0 && ctl_b[1] == 1'b1) frz++;
        end
        chk("lb3 bubble cycles", keep0, 3);
        chk("lb3 freeze cycles", frz, 3);
        step(idle);
        chk("lb3 back to run", int'(ctl_b), 5'b11011);

        // 4-bit counter saturation, then asynchronous reset inside MEM_WAIT
        do_reset();
        for (int c = 0; c < 20; c++) step(mk(0, 0, 0, 0, 0, 1, 0));
        chk("cnt4 saturated", int'(cnt_c), 15);
        chk("cnt4 frozen", int'(ctl_c), 5'b00010);
        do_reset();
        step(idle);
        chk("after reset run", int'(ctl_c), 5'b11011);

        // random traffic on narrow register indices so hazards are frequent
        for (int c = 0; c < 600; c++) begin
            v.memread = 1'($urandom_range(0, 1));
            v.idex_rt = 5'($urandom_range(0, 3));
            v.rs      = 5'($urandom_range(0, 3));
            v.rt      = 5'($urandom_range(0, 3));
            v.br      = ($urandom_range(0, 3) == 0);
            v.req     = ($urandom_range(0, 2) == 0);
            v.ready   = 1'($urandom_range(0, 1));
            step(v);
            if (c == 300) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
